fetch_decode: RTL and testbench

Front stage of the two-stage processor: fetches one 32-bit instruction per cycle from a combinational-read instruction memory, decodes it, reads an 8×32 register file and issues registered operands and control to the execute stage. It also owns register-file writeback: it tracks the destination of every issued instruction and writes the execute stage's registered `aluout` back two cycles after issue. RAW hazards are resolved with a one-cycle bubble plus a writeback bypass.

---
 rtl/fd_pkg.sv | 53 +++++
 rtl/fd_regfile.sv | 31 +++
 rtl/fetch_decode.sv | 134 +++++++++++++
 tb/tb_fetch_decode.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// fd_pkg: shared definitions for the fetch/decode front stage.
// Instruction field positions, class encodings, control_out layout,
// writeback tracking slot and the front-stage FSM states.
package fd_pkg;

  localparam int NREGS = 8;

  // Instruction field positions
  localparam int OPSEL_HI   = 31;
  localparam int OPSEL_LO   = 29;
  localparam int OPER_HI    = 28;
  localparam int OPER_LO    = 26;
  localparam int IMMSEL_BIT = 25;
  localparam int DST_HI     = 24;
  localparam int DST_LO     = 22;
  localparam int RS1_HI     = 21;
  localparam int RS1_LO     = 19;
  localparam int RS2_HI     = 18;
  localparam int RS2_LO     = 16;
  localparam int IMM_HI     = 15;
  localparam int IMM_LO     = 0;

  // Instruction class encodings
  localparam logic [2:0] OPS_NOP    = 3'b000;
  localparam logic [2:0] OPS_MEM_WR = 3'b011;
  localparam logic [2:0] OPS_HALT   = 3'b111;
  localparam logic [2:0] OPER_HALT  = 3'b111;

  // control_out = {imm_sel, opselect[2:0], operation[2:0]}
  localparam int CTRL_IMMSEL   = 6;
  localparam int CTRL_OPSEL_HI = 5;
  localparam int CTRL_OPSEL_LO = 3;
  localparam int CTRL_OPER_HI  = 2;
  localparam int CTRL_OPER_LO  = 0;

  typedef enum logic [1:0] {
    FD_RUN    = 2'd0,
    FD_BUBBLE = 2'd1,
    FD_HALT   = 2'd2
  } fd_state_t;

  // One stage of the writeback tracking pipeline
  typedef struct packed {
    logic       valid;
    logic [2:0] dst;
  } wb_slot_t;

  // True when a pending writeback targets the given register
  function automatic logic slot_hits(input wb_slot_t slot, input logic [2:0] r);
    return slot.valid && (slot.dst == r);
  endfunction

endpackage

// File: rtl/fd_regfile.sv
// fd_regfile: 8x32 register file, two combinational read ports,
// one synchronous write port, synchronous clear on reset.
module fd_regfile
  import fd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  raddr1,
  input  logic [2:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [NREGS];

  // Register storage: cleared on reset, otherwise written when we is high
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: front stage of the two-stage processor. Fetches one
// instruction per cycle, decodes it, reads the register file and issues
// registered operands/control to execute. Tracks issued destinations and
// writes the execute result back two cycles after issue.
// Optional feature macro: FD_BYPASS_EN (writeback bypass from aluout_in;
// when undefined, hazards also stall against the second writeback slot).
module fetch_decode
  import fd_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_fd,
  input  logic [31:0] instr_mem_data_in,
  input  logic [31:0] aluout_in,
  output logic [31:0] instr_mem_addr,
  output logic        enable_ex,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [31:0] imm,
  output logic [6:0]  control_out,
  output logic        halted
);

  fd_state_t   state, state_next;
  wb_slot_t    wb1, wb2;
  logic [31:0] pc;

  logic [2:0]  opselect, operation, dst, rs1, rs2;
  logic        imm_sel;
  logic [15:0] imm16;
  logic        is_nop, is_halt, writes_back, reads_rs2;
  logic        hazard, issue, advance;
  logic [31:0] rf_rdata1, rf_rdata2, operand1, operand2;

  assign opselect  = instr_mem_data_in[OPSEL_HI:OPSEL_LO];
  assign operation = instr_mem_data_in[OPER_HI:OPER_LO];
  assign imm_sel   = instr_mem_data_in[IMMSEL_BIT];
  assign dst       = instr_mem_data_in[DST_HI:DST_LO];
  assign rs1       = instr_mem_data_in[RS1_HI:RS1_LO];
  assign rs2       = instr_mem_data_in[RS2_HI:RS2_LO];
  assign imm16     = instr_mem_data_in[IMM_HI:IMM_LO];

  assign is_halt     = (opselect == OPS_HALT) && (operation == OPER_HALT);
  assign is_nop      = (opselect == OPS_NOP);
  assign writes_back = !is_nop && !is_halt && (opselect != OPS_MEM_WR);
  assign reads_rs2   = !imm_sel;

  fd_regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (wb2.valid),
    .waddr  (wb2.dst),
    .wdata  (aluout_in)
  );

`ifdef FD_BYPASS_EN
  assign hazard   = slot_hits(wb1, rs1) || (reads_rs2 && slot_hits(wb1, rs2));
  assign operand1 = slot_hits(wb2, rs1) ? aluout_in : rf_rdata1;
  assign operand2 = slot_hits(wb2, rs2) ? aluout_in : rf_rdata2;
`else
  assign hazard   = slot_hits(wb1, rs1) || slot_hits(wb2, rs1) ||
                    (reads_rs2 && (slot_hits(wb1, rs2) || slot_hits(wb2, rs2)));
  assign operand1 = rf_rdata1;
  assign operand2 = rf_rdata2;
`endif

  // Next-state and issue decisions; BUBBLE re-evaluates the held instruction like RUN
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    advance    = 1'b0;
    case (state)
      FD_RUN, FD_BUBBLE: begin
        if (enable_fd) begin
          if (is_halt) begin
            state_next = FD_HALT;
          end else if (is_nop) begin
            advance    = 1'b1;
            state_next = FD_RUN;
          end else if (hazard) begin
            state_next = FD_BUBBLE;
          end else begin
            issue      = 1'b1;
            advance    = 1'b1;
            state_next = FD_RUN;
          end
        end
      end
      FD_HALT:  state_next = FD_HALT;
      default:  state_next = FD_RUN;
    endcase
  end

  // PC, FSM, issue registers and writeback tracking; wb pipeline shifts every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FD_RUN;
      pc          <= RESET_PC;
      enable_ex   <= 1'b0;
      src1        <= '0;
      src2        <= '0;
      imm         <= '0;
      control_out <= '0;
      wb1         <= '0;
      wb2         <= '0;
    end else begin
      state     <= state_next;
      enable_ex <= issue;
      if (advance) pc <= pc + 32'd1;
      if (issue) begin
        src1                                     <= operand1;
        src2                                     <= operand2;
        imm                                      <= {{16{imm16[15]}}, imm16};
        control_out[CTRL_IMMSEL]                 <= imm_sel;
        control_out[CTRL_OPSEL_HI:CTRL_OPSEL_LO] <= opselect;
        control_out[CTRL_OPER_HI:CTRL_OPER_LO]   <= operation;
      end
      wb1.valid <= issue && writes_back;
      wb1.dst   <= dst;
      wb2       <= wb1;
    end
  end

  assign instr_mem_addr = pc;
  assign halted         = (state == FD_HALT);

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: randomized and directed self-checking bench for fetch_decode.
// The reference model works at the architectural level: a register value
// array updated in program order, plus a per-register record of the cycle
// each producer was issued, from which stall cycles follow by distance.
// Observes FD_BYPASS_EN the same way the design does.
module tb_fetch_decode;
  import fd_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable_fd;
  logic [31:0] aluout_in;
  wire  [31:0] instr_mem_data_in;
  wire  [31:0] instr_mem_addr, src1, src2, imm;
  wire         enable_ex, halted;
  wire  [6:0]  control_out;

  logic        wrap_reset;
  wire  [31:0] wrap_addr, wrap_src1, wrap_src2, wrap_imm;
  wire         wrap_enable_ex, wrap_halted;
  wire  [6:0]  wrap_control;

  logic [31:0] imem [256];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_pc, m_src1, m_src2, m_imm;
  logic [6:0]  m_ctrl;
  logic        m_en_ex, m_halted, m_check_src2, m_after_reset;
  logic [31:0] arch [8];
  int          last_wr [8];
  logic [31:0] alu_slot [4];
  int          cyc;

  always #5 clk = ~clk;

  assign instr_mem_data_in = imem[instr_mem_addr[7:0]];

  fetch_decode u_dut (
    .clk               (clk),
    .reset             (reset),
    .enable_fd         (enable_fd),
    .instr_mem_data_in (instr_mem_data_in),
    .aluout_in         (aluout_in),
    .instr_mem_addr    (instr_mem_addr),
    .enable_ex         (enable_ex),
    .src1              (src1),
    .src2              (src2),
    .imm               (imm),
    .control_out       (control_out),
    .halted            (halted)
  );

  fetch_decode #(.RESET_PC(32'hFFFF_FFFE)) u_wrap (
    .clk               (clk),
    .reset             (wrap_reset),
    .enable_fd         (1'b1),
    .instr_mem_data_in (32'h0),
    .aluout_in         (32'h0),
    .instr_mem_addr    (wrap_addr),
    .enable_ex         (wrap_enable_ex),
    .src1              (wrap_src1),
    .src2              (wrap_src2),
    .imm               (wrap_imm),
    .control_out       (wrap_control),
    .halted            (wrap_halted)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] ops, input logic [2:0] oper,
                                     input logic isel, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b,
                                     input logic [15:0] i16);
    return {ops, oper, isel, d, a, b, i16};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [2:0] ops, oper;
    k = $urandom_range(0, 99);
    if (k < 8)  return 32'h0;
    if (k < 9)  return {3'b111, 3'b111, 26'h0};
    ops  = 3'($urandom_range(1, 7));
    oper = 3'($urandom_range(0, 7));
    if (ops == 3'b111 && oper == 3'b111) oper = 3'b000;
    return mk(ops, oper, 1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom));
  endfunction

  // A read register is blocked while its producer is still too recent
  function automatic logic too_close(input logic [2:0] r);
    int d;
    d = cyc - last_wr[r];
`ifdef FD_BYPASS_EN
    return d == 1;
`else
    return (d == 1) || (d == 2);
`endif
  endfunction

  task automatic modelReset();
    m_pc = 32'h0; m_src1 = 0; m_src2 = 0; m_imm = 0; m_ctrl = 0;
    m_en_ex = 0; m_halted = 0; m_check_src2 = 1; m_after_reset = 1;
    for (int i = 0; i < 8; i++) begin arch[i] = 0; last_wr[i] = -100; end
  endtask

  task automatic modelDecode();
    logic [31:0] ins, sx, res;
    logic [2:0]  ops, oper, d, a, b;
    logic        isel;
    ins  = imem[m_pc[7:0]];
    ops  = ins[31:29]; oper = ins[28:26]; isel = ins[25];
    d    = ins[24:22]; a = ins[21:19]; b = ins[18:16];
    sx   = {{16{ins[15]}}, ins[15:0]};
    if (ops == 3'b111 && oper == 3'b111) begin
      m_halted = 1;
    end else if (ops == OPS_NOP) begin
      m_pc = m_pc + 1;
    end else if (!(too_close(a) || (!isel && too_close(b)))) begin
      m_en_ex = 1; m_src1 = arch[a]; m_src2 = arch[b]; m_check_src2 = !isel;
      m_imm = sx; m_ctrl = {isel, ops, oper}; m_pc = m_pc + 1;
      if (ops != OPS_MEM_WR) begin
        res = arch[a] + (isel ? sx : arch[b]);
        arch[d] = res; last_wr[d] = cyc; alu_slot[(cyc + 2) % 4] = res;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("instr_mem_addr", instr_mem_addr, m_pc);
    checkOutput("enable_ex", {31'h0, enable_ex}, {31'h0, m_en_ex});
    checkOutput("halted", {31'h0, halted}, {31'h0, m_halted});
    if (m_en_ex || m_after_reset) begin
      checkOutput("src1", src1, m_src1);
      checkOutput("imm", imm, m_imm);
      checkOutput("control_out", {25'h0, control_out}, {25'h0, m_ctrl});
      if (m_check_src2) checkOutput("src2", src2, m_src2);
    end
  endtask

  // Drive one cycle of inputs (at negedge), step the model, then check after the edge
  task automatic applyStimulus(input logic rst, input logic en);
    reset     = rst;
    enable_fd = en;
    aluout_in = alu_slot[cyc % 4];
    alu_slot[(cyc + 2) % 4] = $urandom;
    m_after_reset = 0;
    m_en_ex = 0;
    if (rst) modelReset();
    else if (!m_halted && en) modelDecode();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compareAll();
  endtask

  task automatic loadProgram(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0] = p0; imem[1] = p1; imem[2] = p2;
  endtask

  task automatic runProgram(input logic [31:0] p0, input logic [31:0] p1,
                            input logic [31:0] p2, input int n);
    loadProgram(p0, p1, p2);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    for (int i = 0; i < n; i++) applyStimulus(0, 1);
  endtask

  initial begin
    logic [31:0] exp_wrap;
    logic [31:0] addi_r1_5, addi_r2_7, add_r3_r1_r1, add_r3_r1_r0, addi_r4_9, halt_i, add_r5_r1_r1;
    reset = 1; enable_fd = 1; aluout_in = 0; wrap_reset = 1; cyc = 0;
    for (int i = 0; i < 4; i++) alu_slot[i] = $urandom;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    modelReset();

    addi_r1_5    = mk(3'b001, 3'b000, 1'b1, 3'd1, 3'd0, 3'd0, 16'd5);
    addi_r2_7    = mk(3'b001, 3'b000, 1'b1, 3'd2, 3'd0, 3'd0, 16'd7);
    add_r3_r1_r1 = mk(3'b001, 3'b000, 1'b0, 3'd3, 3'd1, 3'd1, 16'd0);
    add_r3_r1_r0 = mk(3'b001, 3'b000, 1'b0, 3'd3, 3'd1, 3'd0, 16'd0);
    addi_r4_9    = mk(3'b001, 3'b000, 1'b1, 3'd4, 3'd0, 3'd0, 16'd9);
    add_r5_r1_r1 = mk(3'b001, 3'b000, 1'b0, 3'd5, 3'd1, 3'd1, 16'd0);
    halt_i       = {3'b111, 3'b111, 26'h0};

    // PC wrap from 32'hFFFFFFFF to 0 on a second instance
    @(negedge clk);
    checkOutput("wrap_reset_pc", wrap_addr, 32'hFFFF_FFFE);
    wrap_reset = 0;
    exp_wrap = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_wrap = exp_wrap + 1;
      checkOutput("wrap_pc", wrap_addr, exp_wrap);
    end

    // Directed programs from the test plan
    runProgram(32'h0, 32'h0, 32'h0, 3);
    runProgram(addi_r1_5, addi_r2_7, 32'h0, 5);
    runProgram(addi_r1_5, add_r3_r1_r1, 32'h0, 6);
    runProgram(addi_r1_5, addi_r2_7, add_r3_r1_r0, 7);
    runProgram(addi_r4_9, halt_i, 32'h0, 6);

    // Reset in the bubble cycle; afterwards r1 must still read 0
    loadProgram(addi_r1_5, add_r3_r1_r1, 32'h0);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    checkOutput("bubble_seen", {31'h0, enable_ex}, 32'h0);
    loadProgram(add_r5_r1_r1, 32'h0, 32'h0);
    applyStimulus(1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1);

    // Randomized programs with occasional enable drop and reset
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 256; i++) imem[i] = rand_instr();
      applyStimulus(1, 1);
      applyStimulus(1, 1);
      for (int i = 0; i < 200; i++)
        applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
